// File: rtl/lamp_fpu_cmp_issue_if.sv
// lamp_fpu_cmp_issue_if
// Request/response bundle between a requester and the bfloat16 compare
// issue front-end (lamp_fpu_cmp_issue).
//   req_valid_i / req_ready_o : request handshake
//   req_op_i                  : 0=EQ 1=LT 2=LE 3=MIN 4=MAX (5..7 illegal)
//   req_a_i / req_b_i         : packed operands, W bits each
//   rsp_valid_o / rsp_ready_i : response handshake
//   rsp_data_o                : compare bit or selected operand
//   rsp_invalid_o             : invalid-operation flag for this response
// Modports: master = requester side, slave = the issue front-end.
interface lamp_fpu_cmp_issue_if #(
   parameter int W = 16
);
   logic         req_valid_i;
   logic         req_ready_o;
   logic [2:0]   req_op_i;
   logic [W-1:0] req_a_i;
   logic [W-1:0] req_b_i;
   logic         rsp_valid_o;
   logic         rsp_ready_i;
   logic [W-1:0] rsp_data_o;
   logic         rsp_invalid_o;

   modport master (
      output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_invalid_o
   );

   modport slave (
      input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_invalid_o
   );
endinterface

// File: rtl/lamp_fpu_cmp_issue.sv
// lamp_fpu_cmp_issue
// Request/response front-end for the bfloat16 compare datapath. A request is
// latched in IDLE, unpacked and classified, one compare strobe is issued to the
// downstream compare unit, its registered result is captured and then held in
// a response register until the consumer accepts it. A sticky invalid flag
// collects accepted invalid responses for the FPU status register.
// Optional feature macro: LAMP_FPU_CMP_MINMAX_EN enables MIN (op 3) and
// MAX (op 4); without it those opcodes are answered as illegal.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   bus (slave)         request/response handshake bundle
//   clr_flags_i         clears invalid_sticky_o
//   invalid_sticky_o    OR of accepted rsp_invalid_o since last clear
//   doEq_o/doLt_o/doLe_o one-cycle strobes to the compare unit
//   opX*_o, isX*_o      unpacked operand fields and class flags (from latches)
//   cmp_i, cmp_valid_i, cmp_invalid_i  registered compare-unit result
module lamp_fpu_cmp_issue #(
   parameter int E_DW = 8,
   parameter int F_DW = 7,
   localparam int W = 1 + E_DW + F_DW
) (
   input  logic               clk,
   input  logic               rst,
   lamp_fpu_cmp_issue_if.slave bus,
   input  logic               clr_flags_i,
   output logic               invalid_sticky_o,
   output logic               doEq_o,
   output logic               doLt_o,
   output logic               doLe_o,
   output logic               opASign_o,
   output logic [E_DW-1:0]    opAExp_o,
   output logic [F_DW-1:0]    opAFract_o,
   output logic               opBSign_o,
   output logic [E_DW-1:0]    opBExp_o,
   output logic [F_DW-1:0]    opBFract_o,
   output logic               isAZer_o,
   output logic               isASNaN_o,
   output logic               isAQNaN_o,
   output logic               isBZer_o,
   output logic               isBSNaN_o,
   output logic               isBQNaN_o,
   input  logic               cmp_i,
   input  logic               cmp_valid_i,
   input  logic               cmp_invalid_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

   localparam logic [2:0] OP_EQ  = 3'd0;
   localparam logic [2:0] OP_LT  = 3'd1;
   localparam logic [2:0] OP_LE  = 3'd2;
   localparam logic [2:0] OP_MIN = 3'd3;
   localparam logic [2:0] OP_MAX = 3'd4;

   stateT state, nextState;

   logic [W-1:0] opA, opB;
   logic [2:0]   opReg;
   logic [W-1:0] rspData;
   logic         rspInvalid;
   logic         sticky;

   logic         reqLegal;
   logic         loadReq, capture, rspFire;
   logic         reqReady, rspValid;
   logic         doEq, doLt, doLe;
   logic [W-1:0] capData;
   logic         capInvalid;

   logic aNaN, bNaN;

   // Unpacked fields and classification come straight from the latched
   // operands so they stay stable for the whole operation.
   assign opASign_o  = opA[W-1];
   assign opAExp_o   = opA[W-2:F_DW];
   assign opAFract_o = opA[F_DW-1:0];
   assign opBSign_o  = opB[W-1];
   assign opBExp_o   = opB[W-2:F_DW];
   assign opBFract_o = opB[F_DW-1:0];

   assign aNaN = (&opAExp_o) && (|opAFract_o);
   assign bNaN = (&opBExp_o) && (|opBFract_o);

   assign isAZer_o  = (opAExp_o == '0) && (opAFract_o == '0);
   assign isBZer_o  = (opBExp_o == '0) && (opBFract_o == '0);
   assign isAQNaN_o = aNaN &&  opAFract_o[F_DW-1];
   assign isASNaN_o = aNaN && !opAFract_o[F_DW-1];
   assign isBQNaN_o = bNaN &&  opBFract_o[F_DW-1];
   assign isBSNaN_o = bNaN && !opBFract_o[F_DW-1];

   // Which opcodes are actually served; everything else is answered at once
   // as an invalid operation without touching the compare unit.
`ifdef LAMP_FPU_CMP_MINMAX_EN
   assign reqLegal = (bus.req_op_i <= OP_MAX);
`else
   assign reqLegal = (bus.req_op_i <= OP_LE);
`endif

   // Response value formed from the compare unit's result. MIN/MAX reuse the
   // LT compare and then pick an operand, with NaN operands steered around.
`ifdef LAMP_FPU_CMP_MINMAX_EN
   localparam logic [W-1:0] CANON_QNAN = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};

   always_comb begin
      capData    = {{(W-1){1'b0}}, cmp_i};
      capInvalid = cmp_invalid_i;
      if ((opReg == OP_MIN) || (opReg == OP_MAX)) begin
         capInvalid = isASNaN_o || isBSNaN_o;
         if (aNaN && bNaN)
            capData = CANON_QNAN;
         else if (aNaN)
            capData = opB;
         else if (bNaN)
            capData = opA;
         else if (opReg == OP_MIN)
            capData = cmp_i ? opA : opB;
         else
            capData = cmp_i ? opB : opA;
      end
   end
`else
   always_comb begin
      capData    = {{(W-1){1'b0}}, cmp_i};
      capInvalid = cmp_invalid_i;
   end
`endif

   // State register; reset from any state aborts the operation in flight.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= nextState;
   end

   // Next-state and handshake/strobe decode. Only IDLE accepts requests, so
   // a response and a new request never overlap.
   always_comb begin
      nextState = state;
      reqReady  = 1'b0;
      rspValid  = 1'b0;
      doEq      = 1'b0;
      doLt      = 1'b0;
      doLe      = 1'b0;
      loadReq   = 1'b0;
      capture   = 1'b0;
      rspFire   = 1'b0;
      case (state)
         IDLE: begin
            reqReady = 1'b1;
            if (bus.req_valid_i) begin
               loadReq   = 1'b1;
               nextState = reqLegal ? ISSUE : RESP;
            end
         end
         ISSUE: begin
            case (opReg)
               OP_EQ:   doEq = 1'b1;
               OP_LE:   doLe = 1'b1;
               default: doLt = 1'b1;
            endcase
            nextState = WAIT;
         end
         WAIT: begin
            if (cmp_valid_i) begin
               capture   = 1'b1;
               nextState = RESP;
            end
         end
         RESP: begin
            rspValid = 1'b1;
            if (bus.rsp_ready_i) begin
               rspFire   = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Operand latches and the response register. Illegal requests fill the
   // response immediately; legal ones wait for the compare unit.
   always_ff @(posedge clk) begin
      if (rst) begin
         opA        <= '0;
         opB        <= '0;
         opReg      <= '0;
         rspData    <= '0;
         rspInvalid <= 1'b0;
      end else begin
         if (loadReq) begin
            opA   <= bus.req_a_i;
            opB   <= bus.req_b_i;
            opReg <= bus.req_op_i;
            if (!reqLegal) begin
               rspData    <= '0;
               rspInvalid <= 1'b1;
            end
         end
         if (capture) begin
            rspData    <= capData;
            rspInvalid <= capInvalid;
         end
      end
   end

   // Sticky invalid flag; a setting handshake wins over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst)
         sticky <= 1'b0;
      else if (rspFire && rspInvalid)
         sticky <= 1'b1;
      else if (clr_flags_i)
         sticky <= 1'b0;
   end

   assign bus.req_ready_o   = reqReady;
   assign bus.rsp_valid_o   = rspValid;
   assign bus.rsp_data_o    = rspData;
   assign bus.rsp_invalid_o = rspInvalid;
   assign invalid_sticky_o  = sticky;
   assign doEq_o            = doEq;
   assign doLt_o            = doLt;
   assign doLe_o            = doLe;

endmodule

// File: tb/tb_lamp_fpu_cmp_issue.sv
// tb_lamp_fpu_cmp_issue
// Directed self-checking bench for lamp_fpu_cmp_issue. The bench plays the
// role of the compare unit, answering one cycle after the strobe with
// hand-computed result bits.
module tb_lamp_fpu_cmp_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        clrFlags;
   logic        sticky;
   logic        doEq, doLt, doLe;
   logic        opASign, opBSign;
   logic [7:0]  opAExp, opBExp;
   logic [6:0]  opAFract, opBFract;
   logic        isAZer, isASNaN, isAQNaN, isBZer, isBSNaN, isBQNaN;
   logic        cmpRes, cmpValid, cmpInv;

   int checkCount = 0;
   int errorCount = 0;

   lamp_fpu_cmp_issue_if #(.W(16)) bus ();

   lamp_fpu_cmp_issue dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus),
      .clr_flags_i      (clrFlags),
      .invalid_sticky_o (sticky),
      .doEq_o           (doEq),
      .doLt_o           (doLt),
      .doLe_o           (doLe),
      .opASign_o        (opASign),
      .opAExp_o         (opAExp),
      .opAFract_o       (opAFract),
      .opBSign_o        (opBSign),
      .opBExp_o         (opBExp),
      .opBFract_o       (opBFract),
      .isAZer_o         (isAZer),
      .isASNaN_o        (isASNaN),
      .isAQNaN_o        (isAQNaN),
      .isBZer_o         (isBZer),
      .isBSNaN_o        (isBSNaN),
      .isBQNaN_o        (isBQNaN),
      .cmp_i            (cmpRes),
      .cmp_valid_i      (cmpValid),
      .cmp_invalid_i    (cmpInv)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, actual, expected);
      end
   endtask

   // Runs one request up to the response phase. expStrobe is {eq,lt,le};
   // legal=0 means the request must bypass the compare unit entirely.
   task automatic applyStimulus(input string tag, input logic [2:0] op,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic res, input logic inv, input logic legal,
                                input logic [2:0] expStrobe, input logic [15:0] expData,
                                input logic expInv, input logic checkInv);
      @(negedge clk);
      checkOutput({tag, " reqReady"}, 16'(bus.req_ready_o), 16'h1);
      bus.req_valid_i = 1'b1;
      bus.req_op_i    = op;
      bus.req_a_i     = a;
      bus.req_b_i     = b;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      @(negedge clk);
      checkOutput({tag, " strobes c1"}, 16'({doEq, doLt, doLe}), 16'(expStrobe));
      if (legal) begin
         checkOutput({tag, " rspValid c1"}, 16'(bus.rsp_valid_o), 16'h0);
         @(posedge clk);
         #1;
         cmpValid = 1'b1;
         cmpRes   = res;
         cmpInv   = inv;
         @(negedge clk);
         checkOutput({tag, " strobes c2"}, 16'({doEq, doLt, doLe}), 16'h0);
         checkOutput({tag, " rspValid c2"}, 16'(bus.rsp_valid_o), 16'h0);
         @(posedge clk);
         #1;
         cmpValid = 1'b0;
         cmpRes   = 1'b0;
         cmpInv   = 1'b0;
         @(negedge clk);
      end
      checkOutput({tag, " rspValid"}, 16'(bus.rsp_valid_o), 16'h1);
      checkOutput({tag, " reqReady rsp"}, 16'(bus.req_ready_o), 16'h0);
      checkOutput({tag, " data"}, bus.rsp_data_o, expData);
      if (checkInv)
         checkOutput({tag, " invalid"}, 16'(bus.rsp_invalid_o), 16'(expInv));
   endtask

   // Accepts the pending response and confirms the return to IDLE.
   task automatic acceptResponse(input string tag, input logic expSticky);
      @(negedge clk);
      bus.rsp_ready_i = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready_i = 1'b0;
      @(negedge clk);
      checkOutput({tag, " rspValid idle"}, 16'(bus.rsp_valid_o), 16'h0);
      checkOutput({tag, " reqReady idle"}, 16'(bus.req_ready_o), 16'h1);
      checkOutput({tag, " sticky"}, 16'(sticky), 16'(expSticky));
   endtask

   initial begin
      rst             = 1'b1;
      clrFlags        = 1'b0;
      cmpRes          = 1'b0;
      cmpValid        = 1'b0;
      cmpInv          = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.req_op_i    = 3'd0;
      bus.req_a_i     = 16'h0;
      bus.req_b_i     = 16'h0;
      bus.rsp_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset reqReady", 16'(bus.req_ready_o), 16'h1);
      checkOutput("reset rspValid", 16'(bus.rsp_valid_o), 16'h0);
      checkOutput("reset data", bus.rsp_data_o, 16'h0);
      checkOutput("reset sticky", 16'(sticky), 16'h0);
      checkOutput("reset strobes", 16'({doEq, doLt, doLe}), 16'h0);

      // 1.0 < 2.0
      applyStimulus("LT 1<2", 3'd1, 16'h3F80, 16'h4000, 1'b1, 1'b0, 1'b1,
                    3'b010, 16'h0001, 1'b0, 1'b1);
      checkOutput("LT opAExp", 16'(opAExp), 16'h007F);
      checkOutput("LT opBExp", 16'(opBExp), 16'h0080);
      acceptResponse("LT 1<2", 1'b0);

      // +0 == -0
      applyStimulus("EQ zeros", 3'd0, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b1,
                    3'b100, 16'h0001, 1'b0, 1'b1);
      checkOutput("EQ isAZer", 16'(isAZer), 16'h1);
      checkOutput("EQ isBZer", 16'(isBZer), 16'h1);
      checkOutput("EQ opBSign", 16'(opBSign), 16'h1);
      acceptResponse("EQ zeros", 1'b0);

      // -2.0 <= -1.0
      applyStimulus("LE neg", 3'd2, 16'hC000, 16'hBF80, 1'b1, 1'b0, 1'b1,
                    3'b001, 16'h0001, 1'b0, 1'b1);
      acceptResponse("LE neg", 1'b0);

      // Quiet NaN compares unequal without signalling
      applyStimulus("EQ qnan", 3'd0, 16'h7FC0, 16'h3F80, 1'b0, 1'b0, 1'b1,
                    3'b100, 16'h0000, 1'b0, 1'b1);
      checkOutput("EQ isAQNaN", 16'(isAQNaN), 16'h1);
      checkOutput("EQ isASNaN", 16'(isASNaN), 16'h0);
      acceptResponse("EQ qnan", 1'b0);

      // Ordered compare with a NaN signals invalid, which sticks
      applyStimulus("LT qnan", 3'd1, 16'h7FC0, 16'h3F80, 1'b0, 1'b1, 1'b1,
                    3'b010, 16'h0000, 1'b1, 1'b1);
      acceptResponse("LT qnan", 1'b1);
      @(negedge clk);
      clrFlags = 1'b1;
      @(posedge clk);
      #1 clrFlags = 1'b0;
      @(negedge clk);
      checkOutput("sticky cleared", 16'(sticky), 16'h0);

      // Consumer back-pressure: response must hold, new requests ignored
      applyStimulus("hold", 3'd1, 16'h3F80, 16'h4000, 1'b1, 1'b0, 1'b1,
                    3'b010, 16'h0001, 1'b0, 1'b1);
      bus.req_valid_i = 1'b1;
      bus.req_op_i    = 3'd0;
      bus.req_a_i     = 16'h4040;
      bus.req_b_i     = 16'h4040;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold rspValid", 16'(bus.rsp_valid_o), 16'h1);
         checkOutput("hold data", bus.rsp_data_o, 16'h0001);
         checkOutput("hold invalid", 16'(bus.rsp_invalid_o), 16'h0);
         checkOutput("hold reqReady", 16'(bus.req_ready_o), 16'h0);
      end
      checkOutput("hold opAExp", 16'(opAExp), 16'h007F);
      bus.req_valid_i = 1'b0;
      acceptResponse("hold", 1'b0);

      // Illegal opcode answered immediately, sets sticky on accept
      applyStimulus("op5", 3'd5, 16'h3F80, 16'h4000, 1'b0, 1'b0, 1'b0,
                    3'b000, 16'h0000, 1'b1, 1'b1);
      acceptResponse("op5", 1'b1);

`ifdef LAMP_FPU_CMP_MINMAX_EN
      // MIN(2.0, 1.0): LT says A<B is false
      applyStimulus("MIN", 3'd3, 16'h4000, 16'h3F80, 1'b0, 1'b0, 1'b1,
                    3'b010, 16'h3F80, 1'b0, 1'b1);
      acceptResponse("MIN", 1'b1);
      // MIN(QNaN, 1.0) returns the number; invalid not checked here
      applyStimulus("MIN qnan", 3'd3, 16'h7FC0, 16'h3F80, 1'b0, 1'b1, 1'b1,
                    3'b010, 16'h3F80, 1'b0, 1'b0);
      acceptResponse("MIN qnan", 1'b1);
      // MAX(SNaN, QNaN): both NaN -> canonical QNaN, SNaN signals invalid
      applyStimulus("MAX snan", 3'd4, 16'h7F81, 16'h7FC0, 1'b0, 1'b1, 1'b1,
                    3'b010, 16'h7FC0, 1'b1, 1'b1);
      checkOutput("MAX isASNaN", 16'(isASNaN), 16'h1);
      acceptResponse("MAX snan", 1'b1);
`else
      applyStimulus("op3 off", 3'd3, 16'h4000, 16'h3F80, 1'b0, 1'b0, 1'b0,
                    3'b000, 16'h0000, 1'b1, 1'b1);
      acceptResponse("op3 off", 1'b1);
`endif

      // Reset while waiting for the compare unit; a late result is ignored
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_op_i    = 3'd1;
      bus.req_a_i     = 16'h3F80;
      bus.req_b_i     = 16'h4000;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      cmpValid = 1'b1;
      cmpRes   = 1'b1;
      @(posedge clk);
      #1;
      cmpValid = 1'b0;
      cmpRes   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("abort rspValid", 16'(bus.rsp_valid_o), 16'h0);
         checkOutput("abort reqReady", 16'(bus.req_ready_o), 16'h1);
      end
      checkOutput("abort data", bus.rsp_data_o, 16'h0);
      checkOutput("abort invalid", 16'(bus.rsp_invalid_o), 16'h0);
      checkOutput("abort sticky", 16'(sticky), 16'h0);
      checkOutput("abort opAExp", 16'(opAExp), 16'h0);
      checkOutput("abort strobes", 16'({doEq, doLt, doLe}), 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
